// File: rtl/control_entrada_datos.sv
`default_nettype none
// ============================================================================
// Module   : control_entrada_datos
// Purpose  : Keypad entry sequencer for the calculator operand storage.
//            Routes digits to operand 1 or 2, clears storage and starts the
//            calculation once both operands are complete.
// Revision : 1.0 - initial release
// ============================================================================
module control_entrada_datos #(
    parameter int unsigned MAX_DIGITOS    = 3,
    parameter logic [3:0]  TECLA_OPERADOR = 4'hA,
    parameter logic [3:0]  TECLA_IGUAL    = 4'hB,
    parameter logic [3:0]  TECLA_BORRAR   = 4'hC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tecla_valida,
    input  logic [3:0] tecla_pre,
    output logic       cargar_numero1,
    output logic       cargar_numero2,
    output logic       reset_datos,
    output logic [3:0] tecla_dato,
    output logic       calcular,
    output logic [1:0] cuenta_digitos,
    output logic [1:0] fase
);

    typedef enum logic [1:0] {
        NUM1         = 2'd0,
        NUM2         = 2'd1,
        RESULTADO    = 2'd2,
        LIMPIA_CARGA = 2'd3
    } estado_t;

    localparam logic [1:0] C_MAX_CUENTA = 2'(MAX_DIGITOS);

    estado_t    fase_q, fase_d;
    logic [1:0] cuenta_q, cuenta_d;
    logic [3:0] dato_q, dato_d;
    logic [3:0] pendiente_q, pendiente_d;
    logic       carga1_q, carga1_d;
    logic       carga2_q, carga2_d;
    logic       borra_q, borra_d;
    logic       calc_q, calc_d;

    logic w_es_digito;
    logic w_hay_hueco;

    assign w_es_digito = (tecla_pre <= 4'd9);
    assign w_hay_hueco = (cuenta_q < C_MAX_CUENTA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fase_q      <= NUM1;
            cuenta_q    <= 2'd0;
            dato_q      <= 4'd0;
            pendiente_q <= 4'd0;
            carga1_q    <= 1'b0;
            carga2_q    <= 1'b0;
            borra_q     <= 1'b0;
            calc_q      <= 1'b0;
        end else begin
            fase_q      <= fase_d;
            cuenta_q    <= cuenta_d;
            dato_q      <= dato_d;
            pendiente_q <= pendiente_d;
            carga1_q    <= carga1_d;
            carga2_q    <= carga2_d;
            borra_q     <= borra_d;
            calc_q      <= calc_d;
        end
    end

    always_comb begin
        fase_d      = fase_q;
        cuenta_d    = cuenta_q;
        dato_d      = dato_q;
        pendiente_d = pendiente_q;
        carga1_d    = 1'b0;
        carga2_d    = 1'b0;
        borra_d     = 1'b0;
        calc_d      = 1'b0;

        if (fase_q == LIMPIA_CARGA) begin
            // Storage was cleared last cycle; now load the digit that started the new entry.
            carga1_d = 1'b1;
            dato_d   = pendiente_q;
            fase_d   = NUM1;
            cuenta_d = 2'd1;
        end else if (tecla_valida) begin
            if (tecla_pre == TECLA_BORRAR) begin
                borra_d  = 1'b1;
                fase_d   = NUM1;
                cuenta_d = 2'd0;
            end else begin
                case (fase_q)
                    NUM1, NUM2: begin
                        if (w_es_digito && w_hay_hueco) begin
                            carga1_d = (fase_q == NUM1);
                            carga2_d = (fase_q == NUM2);
                            dato_d   = tecla_pre;
                            cuenta_d = cuenta_q + 2'd1;
                        end else if ((fase_q == NUM1) && (tecla_pre == TECLA_OPERADOR) &&
                                     (cuenta_q != 2'd0)) begin
                            fase_d   = NUM2;
                            cuenta_d = 2'd0;
                        end else if ((fase_q == NUM2) && (tecla_pre == TECLA_IGUAL) &&
                                     (cuenta_q != 2'd0)) begin
                            calc_d = 1'b1;
                            fase_d = RESULTADO;
                        end
                    end
                    RESULTADO: begin
                        if (w_es_digito) begin
                            borra_d     = 1'b1;
                            pendiente_d = tecla_pre;
                            fase_d      = LIMPIA_CARGA;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign cargar_numero1 = carga1_q;
    assign cargar_numero2 = carga2_q;
    assign reset_datos    = borra_q;
    assign calcular       = calc_q;
    assign tecla_dato     = dato_q;
    assign cuenta_digitos = cuenta_q;
    assign fase           = fase_q;

endmodule
`default_nettype wire

// File: tb/tb_control_entrada_datos.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_entrada_datos
// Purpose  : Directed self-checking bench with an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_entrada_datos;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla_pre = 4'd0;
    logic       cargar_numero1, cargar_numero2, reset_datos, calcular;
    logic [3:0] tecla_dato;
    logic [1:0] cuenta_digitos, fase;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] msk_q[$];
    string       tag_q[$];

    localparam logic [11:0] M_ALL = 12'hFFF;

    always #5 clk = ~clk;

    control_entrada_datos dut (
        .clk            (clk),
        .rst            (rst),
        .tecla_valida   (tecla_valida),
        .tecla_pre      (tecla_pre),
        .cargar_numero1 (cargar_numero1),
        .cargar_numero2 (cargar_numero2),
        .reset_datos    (reset_datos),
        .tecla_dato     (tecla_dato),
        .calcular       (calcular),
        .cuenta_digitos (cuenta_digitos),
        .fase           (fase)
    );

    // Packed layout: {cargar1, cargar2, reset_datos, calcular, tecla_dato, cuenta, fase}
    function automatic logic [11:0] e(input logic c1, input logic c2, input logic rd,
                                      input logic ca, input logic [3:0] d,
                                      input logic [1:0] n, input logic [1:0] f);
        return {c1, c2, rd, ca, d, n, f};
    endfunction

    task automatic expect_out(input logic [11:0] ex, input logic [11:0] m, input string tag);
        exp_q.push_back(ex);
        msk_q.push_back(m);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        logic [11:0] obs, ex, m;
        string       tag;
        obs = {cargar_numero1, cargar_numero2, reset_datos, calcular,
               tecla_dato, cuenta_digitos, fase};
        ex  = exp_q.pop_front();
        m   = msk_q.pop_front();
        tag = tag_q.pop_front();
        total++;
        assert ((obs & m) === (ex & m))
        else begin
            bad++;
            $error("FAIL %s observed=%03h expected=%03h mask=%03h", tag, obs, ex, m);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] k, input logic [11:0] ex,
                        input logic [11:0] m, input string tag);
        @(negedge clk);
        tecla_valida = v;
        tecla_pre    = k;
        expect_out(ex, m, tag);
        @(posedge clk);
        #1;
        tecla_valida = 1'b0;
        check();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        expect_out(e(0,0,0,0,4'd0,2'd0,2'd0), M_ALL, "reset_state");
        check();
        @(negedge clk);
        rst = 1'b0;

        // Keys that must be ignored at power-up
        step(1, 4'hA, e(0,0,0,0,4'd0,2'd0,2'd0), M_ALL, "op_no_digits");
        step(1, 4'hB, e(0,0,0,0,4'd0,2'd0,2'd0), M_ALL, "eq_in_num1");
        step(1, 4'hE, e(0,0,0,0,4'd0,2'd0,2'd0), M_ALL, "key_E_num1");

        // Operand 1
        step(1, 4'h5, e(1,0,0,0,4'd5,2'd1,2'd0), M_ALL, "n1_digit5");
        step(0, 4'h0, e(0,0,0,0,4'd5,2'd1,2'd0), M_ALL, "n1_idle");
        step(1, 4'h3, e(1,0,0,0,4'd3,2'd2,2'd0), M_ALL, "n1_digit3");
        step(1, 4'h6, e(1,0,0,0,4'd6,2'd3,2'd0), M_ALL, "n1_digit6");
        step(1, 4'h7, e(0,0,0,0,4'd6,2'd3,2'd0), M_ALL, "n1_saturated");
        step(1, 4'hA, e(0,0,0,0,4'd6,2'd0,2'd1), M_ALL, "op_to_num2");

        // Operand 2
        step(1, 4'hB, e(0,0,0,0,4'd6,2'd0,2'd1), M_ALL, "eq_empty_num2");
        step(1, 4'hA, e(0,0,0,0,4'd6,2'd0,2'd1), M_ALL, "op_in_num2");
        step(1, 4'h9, e(0,1,0,0,4'd9,2'd1,2'd1), M_ALL, "n2_digit9");
        step(1, 4'h1, e(0,1,0,0,4'd1,2'd2,2'd1), M_ALL, "n2_digit1");
        step(1, 4'h8, e(0,1,0,0,4'd8,2'd3,2'd1), M_ALL, "n2_digit8");
        step(1, 4'hE, e(0,0,0,0,4'd8,2'd3,2'd1), M_ALL, "key_E_num2");
        step(1, 4'hB, e(0,0,0,1,4'd8,2'd3,2'd2), M_ALL, "calcular");
        step(0, 4'h0, e(0,0,0,0,4'd8,2'd3,2'd2), M_ALL, "calcular_one_cycle");

        // Result phase
        step(1, 4'hA, e(0,0,0,0,4'd8,2'd3,2'd2), M_ALL, "op_in_result");
        step(1, 4'hB, e(0,0,0,0,4'd8,2'd3,2'd2), M_ALL, "eq_in_result");
        step(1, 4'h4, e(0,0,1,0,4'd0,2'd0,2'd3), 12'hF03, "result_digit_clear");
        step(1, 4'h7, e(1,0,0,0,4'd4,2'd1,2'd0), M_ALL, "result_digit_load");
        step(0, 4'h0, e(0,0,0,0,4'd4,2'd1,2'd0), M_ALL, "after_reload");

        // Clear key in NUM2 with two digits
        step(1, 4'hA, e(0,0,0,0,4'd4,2'd0,2'd1), M_ALL, "op_to_num2_b");
        step(1, 4'h2, e(0,1,0,0,4'd2,2'd1,2'd1), M_ALL, "n2b_digit2");
        step(1, 4'h3, e(0,1,0,0,4'd3,2'd2,2'd1), M_ALL, "n2b_digit3");
        step(1, 4'hC, e(0,0,1,0,4'd3,2'd0,2'd0), M_ALL, "clear_key");
        step(0, 4'h0, e(0,0,0,0,4'd3,2'd0,2'd0), M_ALL, "clear_one_cycle");

        // Asynchronous reset while a strobe is high in NUM2
        step(1, 4'h1, e(1,0,0,0,4'd1,2'd1,2'd0), M_ALL, "n1c_digit1");
        step(1, 4'hA, e(0,0,0,0,4'd1,2'd0,2'd1), M_ALL, "op_to_num2_c");
        step(1, 4'h5, e(0,1,0,0,4'd5,2'd1,2'd1), M_ALL, "n2c_digit5");
        #2;
        rst = 1'b1;
        #1;
        expect_out(e(0,0,0,0,4'd0,2'd0,2'd0), M_ALL, "async_reset");
        check();
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'h2, e(1,0,0,0,4'd2,2'd1,2'd0), M_ALL, "post_reset_digit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_entrada_datos.md
Name: control_entrada_datos

Overview:
Sequencing controller for the calculator's operand storage block (almacenamiento_datos). It takes decoded keypad keys and decides which operand each digit is written to. It also generates the load and clear strobes for that storage, counts digits per operand, and pulses a start-of-calculation strobe when both operands are complete. It sits between the keypad decoder/debouncer and the storage/ALU.

Parameters:
MAX_DIGITOS, 3, maximum digits stored per operand (1..3; counter is 2 bits)
TECLA_OPERADOR, 4'hA, key code that closes operand 1 and moves entry to operand 2
TECLA_IGUAL, 4'hB, key code that closes operand 2 and requests calculation
TECLA_BORRAR, 4'hC, key code that clears everything

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
tecla_valida  input  1  one-cycle pulse marking tecla_pre valid
tecla_pre  input  4  decoded key code; 0x0-0x9 are digits
cargar_numero1  output  1  one-cycle strobe: shift tecla_dato into operand 1
cargar_numero2  output  1  one-cycle strobe: shift tecla_dato into operand 2
reset_datos  output  1  one-cycle strobe: clear both operands in storage
tecla_dato  output  4  registered digit that accompanies the load strobes
calcular  output  1  one-cycle strobe: both operands ready
cuenta_digitos  output  2  digits accepted in the current operand
fase  output  2  current state encoding: 0 NUM1, 1 NUM2, 2 RESULTADO, 3 LIMPIA_CARGA

Behaviour:
- Reset (async, any time, including mid-sequence):
  - fase=NUM1, cuenta_digitos=0, tecla_dato=0.
  - All strobes (cargar_numero1, cargar_numero2, reset_datos, calcular) are 0.
  - Takes effect immediately; no strobe completes after rst rises.
- All outputs are registered. A key sampled with tecla_valida=1 at edge N produces its strobe in the cycle after edge N (latency 1). tecla_dato is updated at the same edge as the strobe.
- Only one strobe is high in any cycle. Strobes are 0 in every cycle not listed below.
- Key classes:
  - digit: tecla_pre <= 9
  - operator: TECLA_OPERADOR
  - equals: TECLA_IGUAL
  - clear: TECLA_BORRAR
  - Any other code is ignored.
- Clear (any state except LIMPIA_CARGA):
  - reset_datos pulses; fase goes to NUM1; cuenta_digitos goes to 0.
- NUM1:
  - digit with cuenta_digitos < MAX_DIGITOS: cargar_numero1 pulses, tecla_dato = digit, cuenta_digitos increments.
  - digit when cuenta_digitos = MAX_DIGITOS: ignored (no strobe, no count change).
  - operator with cuenta_digitos >= 1: fase goes to NUM2, cuenta_digitos goes to 0.
  - operator with cuenta_digitos = 0: ignored.
  - equals: ignored.
- NUM2:
  - digit: same rules as NUM1, using cargar_numero2.
  - equals with cuenta_digitos >= 1: calcular pulses, fase goes to RESULTADO, cuenta_digitos holds.
  - equals with cuenta_digitos = 0: ignored.
  - operator: ignored.
- RESULTADO:
  - digit:
    - reset_datos pulses in cycle N+1; fase goes to LIMPIA_CARGA; the digit is latched.
    - In cycle N+2, cargar_numero1 pulses with tecla_dato = latched digit; fase goes to NUM1; cuenta_digitos = 1.
  - operator and equals: ignored.
- LIMPIA_CARGA:
  - Lasts exactly one cycle.
  - tecla_valida in this cycle is ignored, including clear.
- tecla_valida held high for several cycles is treated as one key per high cycle. The upstream debouncer guarantees single-cycle pulses.
- Width rules: cuenta_digitos saturates at MAX_DIGITOS and never wraps. tecla_dato is 4 bits, taken directly from tecla_pre[3:0].

Test Plan:
- Reset, then keys 5,3,6 -> cargar_numero1 pulses three times with tecla_dato 5,3,6, one cycle after each key; cuenta_digitos ends at 3; fase=0.
- After the above, keys 7 then A -> no strobe for 7, cuenta_digitos stays 3; A -> fase=1, cuenta_digitos=0.
- In NUM2, keys 9,1,8 then B -> three cargar_numero2 pulses (9,1,8), then calcular high for exactly one cycle; fase=2.
- Key A at power-up (no digits), and key B with empty NUM2 -> no strobes, fase unchanged; key E anywhere -> ignored.
- In RESULTADO, key 4 -> reset_datos at N+1, cargar_numero1 with tecla_dato=4 at N+2; fase=0, cuenta_digitos=1; a key at N+1 is dropped.
- In NUM2 with 2 digits, key C -> reset_datos one cycle, fase=0, cuenta_digitos=0. Separately, assert rst asynchronously mid-cycle while in NUM2 -> all outputs zero immediately, fase=0.
